// File: rtl/fx3_bus_in_ctrl.sv
// FX3 inbound read sequencer: probes two DMA sockets round-robin, waits out flag latency,
// then grants the in path one packet at a time and counts completed packets.
module fx3_bus_in_ctrl #(
  parameter int unsigned ADDR_SETTLE = 3,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_dma_ready,
  input  logic [23:0] i_packet_size,
  output logic        o_socket_addr,
  output logic        o_in_path_enable,
  output logic        o_read_flow_cntrl,
  output logic [23:0] o_packet_size,
  input  logic        i_in_path_busy,
  input  logic        i_in_path_finished,
  output logic        o_busy,
  output logic [31:0] o_packet_count,
  output logic        o_timeout
);

  localparam logic [3:0]  SETTLE_LOAD = 4'(ADDR_SETTLE - 1);
  localparam logic [16:0] TIMEOUT_L   = 17'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_SETUP = 3'd1,
    ST_CHECK      = 3'd2,
    ST_READ       = 3'd3,
    ST_RELEASE    = 3'd4
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        socket_addr_r;
  logic        socket_addr_nxt_s;
  logic        next_socket_r;
  logic        next_socket_nxt_s;
  logic [3:0]  settle_r;
  logic [3:0]  settle_nxt_s;
  logic [15:0] timeout_cnt_r;
  logic [15:0] timeout_cnt_nxt_s;
  logic        timeout_r;
  logic        timeout_nxt_s;
  logic [23:0] packet_size_r;
  logic [23:0] packet_size_nxt_s;
  logic [31:0] packet_count_r;
  logic [31:0] packet_count_nxt_s;
  logic        in_path_enable_r;
  logic        read_flow_cntrl_r;
  logic        busy_r;
  logic        rdy_meta_r;
  logic        rdy_sync_r;

  // Two-flop synchroniser for the asynchronous FX3 DMA flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_meta_r <= 1'b0;
      rdy_sync_r <= 1'b0;
    end else begin
      rdy_meta_r <= i_dma_ready;
      rdy_sync_r <= rdy_meta_r;
    end
  end

  // Next-state and datapath next values for the sequencer
  always_comb begin
    state_nxt_s        = state_r;
    socket_addr_nxt_s  = socket_addr_r;
    next_socket_nxt_s  = next_socket_r;
    settle_nxt_s       = settle_r;
    timeout_cnt_nxt_s  = timeout_cnt_r;
    timeout_nxt_s      = timeout_r;
    packet_size_nxt_s  = packet_size_r;
    packet_count_nxt_s = packet_count_r;
    case (state_r)
      ST_IDLE: begin
        if (i_enable) begin
          state_nxt_s       = ST_ADDR_SETUP;
          socket_addr_nxt_s = next_socket_r;
          settle_nxt_s      = SETTLE_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR_SETUP: begin
        if (settle_r == 4'd0) begin
          state_nxt_s = ST_CHECK;
        end else begin
          settle_nxt_s = settle_r - 4'd1;
        end
      end
      ST_CHECK: begin
        if (!i_enable) begin
          state_nxt_s = ST_IDLE;
        end else if (rdy_sync_r) begin
          state_nxt_s       = ST_READ;
          packet_size_nxt_s = i_packet_size;
          timeout_cnt_nxt_s = 16'd0;
          if (TIMEOUT_L <= 17'd1) begin
            timeout_nxt_s = 1'b1;
          end else begin
            timeout_nxt_s = timeout_r;
          end
        end else begin
          // Socket not ready: probe the other one so neither can starve
          state_nxt_s       = ST_ADDR_SETUP;
          socket_addr_nxt_s = ~socket_addr_r;
          settle_nxt_s      = SETTLE_LOAD;
        end
      end
      ST_READ: begin
        timeout_cnt_nxt_s = sat_inc16(timeout_cnt_r);
        if (i_in_path_finished) begin
          state_nxt_s        = ST_RELEASE;
          packet_count_nxt_s = packet_count_r + 32'd1;
          next_socket_nxt_s  = ~socket_addr_r;
        end else if (({1'b0, timeout_cnt_r} + 17'd2) >= TIMEOUT_L) begin
          // Counter holds completed READ cycles; the flag is raised so it shows
          // during the TIMEOUT-th READ cycle itself
          timeout_nxt_s = 1'b1;
        end else begin
          timeout_nxt_s = timeout_r;
        end
      end
      ST_RELEASE: begin
        if (!i_in_path_finished && !i_in_path_busy) begin
          if (i_enable) begin
            state_nxt_s       = ST_ADDR_SETUP;
            socket_addr_nxt_s = next_socket_r;
            settle_nxt_s      = SETTLE_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      socket_addr_r     <= 1'b0;
      next_socket_r     <= 1'b0;
      settle_r          <= 4'd0;
      timeout_cnt_r     <= 16'd0;
      timeout_r         <= 1'b0;
      packet_size_r     <= 24'd0;
      packet_count_r    <= 32'd0;
      in_path_enable_r  <= 1'b0;
      read_flow_cntrl_r <= 1'b0;
      busy_r            <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      socket_addr_r     <= socket_addr_nxt_s;
      next_socket_r     <= next_socket_nxt_s;
      settle_r          <= settle_nxt_s;
      timeout_cnt_r     <= timeout_cnt_nxt_s;
      timeout_r         <= timeout_nxt_s;
      packet_size_r     <= packet_size_nxt_s;
      packet_count_r    <= packet_count_nxt_s;
      in_path_enable_r  <= (state_nxt_s == ST_READ);
      read_flow_cntrl_r <= (state_nxt_s == ST_READ);
      busy_r            <= (state_nxt_s != ST_IDLE);
    end
  end

  assign o_socket_addr     = socket_addr_r;
  assign o_in_path_enable  = in_path_enable_r;
  assign o_read_flow_cntrl = read_flow_cntrl_r;
  assign o_packet_size     = packet_size_r;
  assign o_busy            = busy_r;
  assign o_packet_count    = packet_count_r;
  assign o_timeout         = timeout_r;

endmodule

// File: tb/tb_fx3_bus_in_ctrl.sv
// Directed bench for fx3_bus_in_ctrl: a two-socket FX3 flag model plus scenario tasks
// with hand-computed expectations (ADDR_SETTLE=3, TIMEOUT=20).
module tb_fx3_bus_in_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        dma_ready;
  logic [23:0] psize;
  logic        sock;
  logic        ipe;
  logic        rfc;
  logic [23:0] psize_o;
  logic        ip_busy;
  logic        ip_fin;
  logic        busy;
  logic [31:0] pcount;
  logic        tmo;
  logic        rdy0;
  logic        rdy1;

  int checks = 0;
  int passes = 0;

  // FX3 model: each socket has its own ready flag, muxed by the addressed socket
  assign dma_ready = sock ? rdy1 : rdy0;

  always #5 clk = ~clk;

  fx3_bus_in_ctrl #(.ADDR_SETTLE(3), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_dma_ready(dma_ready),
    .i_packet_size(psize), .o_socket_addr(sock), .o_in_path_enable(ipe),
    .o_read_flow_cntrl(rfc), .o_packet_size(psize_o), .i_in_path_busy(ip_busy),
    .i_in_path_finished(ip_fin), .o_busy(busy), .o_packet_count(pcount),
    .o_timeout(tmo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input logic exp_sock, input int len);
    int n;
    n = 0;
    while (ipe !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ipe !== 1'b1) $display("FAIL pkt_start: in_path_enable=%b, required 1 within 40 cycles", ipe);
    else passes++;
    checks++;
    if (sock !== exp_sock) $display("FAIL pkt_socket: socket=%b, required %b", sock, exp_sock);
    else passes++;
    for (int i = 1; i < len; i++) tick();
    ip_fin = 1'b1;
    tick();
    ip_fin = 1'b0;
    checks++;
    if (ipe !== 1'b0) $display("FAIL pkt_release: in_path_enable=%b, required 0", ipe);
    else passes++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    psize = 24'd512; ip_fin = 1'b0; ip_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({sock, ipe, rfc, psize_o, busy, pcount, tmo} !== 61'd0)
        $display("FAIL reset_outputs: outputs=%h, required 0", {sock, ipe, rfc, psize_o, busy, pcount, tmo});
      else passes++;
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || ipe !== 1'b0 || sock !== 1'b0)
      $display("FAIL reset_exit: busy=%b enable=%b socket=%b, required 1 0 0", busy, ipe, sock);
    else passes++;
  endtask

  task automatic test_single_packet;
    int n;
    int hi;
    n = 0;
    while (ipe !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 4) $display("FAIL first_read_latency: cycles=%0d, required 4", n);
    else passes++;
    checks++;
    if (sock !== 1'b0 || rfc !== 1'b1 || psize_o !== 24'd512)
      $display("FAIL read_entry: socket=%b flow=%b size=%0d, required 0 1 512", sock, rfc, psize_o);
    else passes++;
    psize = 24'd100;
    hi = 1;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (ipe === 1'b1) hi++;
    end
    ip_fin = 1'b1;
    tick();
    ip_fin = 1'b0;
    checks++;
    if (hi !== 10) $display("FAIL enable_width: high cycles=%0d, required 10", hi);
    else passes++;
    checks++;
    if (ipe !== 1'b0 || rfc !== 1'b0 || pcount !== 32'd1 || psize_o !== 24'd512)
      $display("FAIL first_release: enable=%b flow=%b count=%0d size=%0d, required 0 0 1 512",
               ipe, rfc, pcount, psize_o);
    else passes++;
    tick();
    checks++;
    if (sock !== 1'b1) $display("FAIL ping_pong: socket=%b, required 1", sock);
    else passes++;
    run_packet(1'b1, 1);
    checks++;
    if (pcount !== 32'd2 || psize_o !== 24'd100)
      $display("FAIL second_packet: count=%0d size=%0d, required 2 100", pcount, psize_o);
    else passes++;
  endtask

  task automatic test_reprobe;
    int t_sw;
    int t_en;
    t_sw = -1;
    t_en = -1;
    rdy0 = 1'b0;
    tick();
    checks++;
    if (sock !== 1'b0) $display("FAIL probe_first: socket=%b, required 0", sock);
    else passes++;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (sock === 1'b1 && t_sw < 0) t_sw = t;
      if (ipe === 1'b1) begin
        t_en = t;
        break;
      end
    end
    checks++;
    if (t_sw !== 4) $display("FAIL probe_toggle: cycle=%0d, required 4", t_sw);
    else passes++;
    checks++;
    if (t_en !== 8 || sock !== 1'b1)
      $display("FAIL probe_read: cycle=%0d socket=%b, required 8 1", t_en, sock);
    else passes++;
    ip_fin = 1'b1;
    tick();
    ip_fin = 1'b0;
    checks++;
    if (pcount !== 32'd3) $display("FAIL probe_count: count=%0d, required 3", pcount);
    else passes++;
  endtask

  task automatic test_release_hold;
    int n;
    int stay;
    rdy0 = 1'b1;
    psize = 24'd0;
    n = 0;
    while (ipe !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ipe !== 1'b1 || sock !== 1'b0 || psize_o !== 24'd0)
      $display("FAIL hold_entry: enable=%b socket=%b size=%0d, required 1 0 0", ipe, sock, psize_o);
    else passes++;
    en = 1'b0;
    tick();
    tick();
    checks++;
    if (ipe !== 1'b1) $display("FAIL enable_drop_ignored: enable=%b, required 1", ipe);
    else passes++;
    en = 1'b1;
    ip_fin = 1'b1;
    tick();
    stay = 0;
    for (int r = 1; r <= 5; r++) begin
      if (busy === 1'b1 && ipe === 1'b0 && sock === 1'b0) stay++;
      if (r < 5) tick();
    end
    checks++;
    if (stay !== 5) $display("FAIL release_hold: cycles held=%0d, required 5", stay);
    else passes++;
    ip_fin = 1'b0;
    ip_busy = 1'b1;
    tick();
    checks++;
    if (sock !== 1'b0) $display("FAIL release_busy_hold: socket=%b, required 0", sock);
    else passes++;
    ip_busy = 1'b0;
    tick();
    checks++;
    if (sock !== 1'b1 || pcount !== 32'd4 || tmo !== 1'b0)
      $display("FAIL release_exit: socket=%b count=%0d timeout=%b, required 1 4 0", sock, pcount, tmo);
    else passes++;
  endtask

  task automatic test_timeout;
    int n;
    int first;
    int hi;
    psize = 24'd7;
    n = 0;
    while (ipe !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    first = -1;
    hi = 0;
    for (int k = 1; k <= 25; k++) begin
      if (tmo === 1'b1 && first < 0) first = k;
      if (ipe === 1'b1) hi++;
      if (k < 25) tick();
    end
    checks++;
    if (first !== 20) $display("FAIL timeout_cycle: first set in READ cycle %0d, required 20", first);
    else passes++;
    checks++;
    if (hi !== 25 || pcount !== 32'd4)
      $display("FAIL timeout_no_abort: enable cycles=%0d count=%0d, required 25 4", hi, pcount);
    else passes++;
  endtask

  task automatic test_reset_mid_read;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({sock, ipe, rfc, psize_o, busy, pcount, tmo} !== 61'd0)
      $display("FAIL mid_read_reset: outputs=%h, required 0", {sock, ipe, rfc, psize_o, busy, pcount, tmo});
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_count_wrap;
    force dut.packet_count_nxt_s = 32'hFFFF_FFFF;
    tick();
    release dut.packet_count_nxt_s;
    checks++;
    if (pcount !== 32'hFFFF_FFFF) $display("FAIL count_preset: count=%h, required ffffffff", pcount);
    else passes++;
    run_packet(1'b0, 3);
    checks++;
    if (pcount !== 32'd0) $display("FAIL count_wrap: count=%h, required 0", pcount);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_reprobe();
    test_release_hold();
    test_timeout();
    test_reset_mid_read();
    test_count_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
